// File: rtl/uart_rx_fifo.sv
// Memory-mapped receive FIFO between the UART receiver and the CPU bus, with
// data/status/control registers and a threshold-based level interrupt.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int         DEPTH     = 16,
  parameter int         PTR_W     = 4,
  parameter logic [7:0] DATA_ADDR = 8'd252,
  parameter logic [7:0] STAT_ADDR = 8'd254,
  parameter logic [7:0] CTRL_ADDR = 8'd248
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [7:0] addr,
  input  logic [7:0] w_data,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] r_data,
  output logic       hit,
  output logic       int_req
);

  localparam int CW = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             int_en;
  logic [3:0]       thr;

  logic             empty;
  logic             full;
  logic             ctrl_wr;
  logic             flush;
  logic             clr_ovf;
  logic             do_pop;
  logic             do_push;
  logic             ovf_set;
  logic [CW-1:0]    count_next;
  logic             overflow_next;
  logic             int_en_next;
  logic [3:0]       thr_next;
  logic [4:0]       thr_ext;
  logic [CW-1:0]    thr_eff;
  logic             int_req_next;
  logic [4:0]       count5;
  logic             unused_w_data3;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign ctrl_wr = w_en && (addr == CTRL_ADDR);
  assign flush   = ctrl_wr && w_data[1];
  assign clr_ovf = ctrl_wr && w_data[2];

  // Reserved control bit is accepted on the bus but has no storage.
  assign unused_w_data3 = w_data[3];

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign do_pop  = r_en && (addr == DATA_ADDR) && !empty && !flush;
  assign do_push = rx_valid && !flush && (!full || do_pop);
  assign ovf_set = rx_valid && !flush && full && !do_pop;

  assign overflow_next = ovf_set || (overflow && !clr_ovf);
  assign int_en_next   = ctrl_wr ? w_data[0]   : int_en;
  assign thr_next      = ctrl_wr ? w_data[7:4] : thr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_comb begin
    thr_ext = {1'b0, thr_next};
    thr_eff = CW'(1);
    if (thr_ext == 5'd0) begin
      thr_eff = CW'(1);
    end else if (thr_ext > 5'(DEPTH)) begin
      thr_eff = CW'(DEPTH);
    end else begin
      thr_eff = CW'(thr_ext);
    end
  end

  // Interrupt tracks the post-update count and control so it moves on the same edge.
  assign int_req_next = int_en_next && (count_next >= thr_eff);

  // NOTE: storage has no reset; its contents are only visible through rd_ptr when count says valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      int_en   <= 1'b0;
      thr      <= 4'd1;
      int_req  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      overflow <= overflow_next;
      int_en   <= int_en_next;
      thr      <= thr_next;
      int_req  <= int_req_next;
    end
  end

  assign count5 = 5'(count);
  assign hit    = (addr == DATA_ADDR) || (addr == STAT_ADDR) || (addr == CTRL_ADDR);

  always_comb begin
    r_data = 8'h00;
    if (addr == DATA_ADDR) begin
      r_data = empty ? 8'h00 : mem[rd_ptr];
    end else if (addr == STAT_ADDR) begin
      r_data = {count5, overflow, full, !empty};
    end else if (addr == CTRL_ADDR) begin
      r_data = {thr, 3'b000, int_en};
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: reads queue expected values, a negedge
// monitor compares whatever the DUT presents on r_data.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam logic [7:0] DATA_A = 8'd252;
  localparam logic [7:0] STAT_A = 8'd254;
  localparam logic [7:0] CTRL_A = 8'd248;

  logic       clock;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] addr;
  logic [7:0] w_data;
  logic       w_en;
  logic       r_en;
  logic [7:0] r_data;
  logic       hit;
  logic       int_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  uart_rx_fifo dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .addr     (addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .r_en     (r_en),
    .r_data   (r_data),
    .hit      (hit),
    .int_req  (int_req)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: whenever the CPU performs a load that hits, compare against the queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && r_en && hit) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%h expected=none", r_data);
      end else begin
        e = sb.pop_front();
        check(e.name, r_data, e.exp);
      end
    end
  end

  task automatic op(input string name, input logic rv, input logic [7:0] rb,
                    input logic [7:0] a, input logic re, input logic we,
                    input logic [7:0] wd, input logic [7:0] exp);
    rx_valid = rv;
    rx_byte  = rb;
    addr     = a;
    r_en     = re;
    w_en     = we;
    w_data   = wd;
    if (re) sb.push_back('{name, exp});
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    r_en     = 1'b0;
    w_en     = 1'b0;
    addr     = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    op("push", 1'b1, b, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    op(name, 1'b0, 8'h00, a, 1'b1, 1'b0, 8'h00, exp);
  endtask

  task automatic wr(input logic [7:0] d);
    op("wr", 1'b0, 8'h00, CTRL_A, 1'b0, 1'b1, d, 8'h00);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    addr     = 8'h00;
    w_data   = 8'h00;
    w_en     = 1'b0;
    r_en     = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset state
    rd("rst_stat", STAT_A, 8'h00);
    rd("rst_ctrl", CTRL_A, 8'h10);
    check("rst_int_req", {7'd0, int_req}, 8'h00);

    // Basic push / pop ordering and empty read
    push(8'h41); push(8'h42); push(8'h43);
    rd("t1_stat3", STAT_A, 8'b00011_0_0_1);
    rd("t1_d0", DATA_A, 8'h41);
    rd("t1_d1", DATA_A, 8'h42);
    rd("t1_d2", DATA_A, 8'h43);
    rd("t1_stat0", STAT_A, 8'h00);
    rd("t1_empty_pop", DATA_A, 8'h00);
    rd("t1_stat_after", STAT_A, 8'h00);
    push(8'h44);
    rd("t1_d3", DATA_A, 8'h44);

    // Full, overflow, same-cycle set and clear, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    rd("t2_stat_ovf", STAT_A, 8'b10000_1_1_1);
    op("t2_set_clr", 1'b1, 8'hBB, CTRL_A, 1'b0, 1'b1, 8'h04, 8'h00);
    rd("t2_stat_ovf_kept", STAT_A, 8'b10000_1_1_1);
    for (int i = 0; i < 16; i++) rd("t2_drain", DATA_A, 8'(i));
    wr(8'h04);
    rd("t2_stat_clr", STAT_A, 8'h00);
    rd("t2_ctrl", CTRL_A, 8'h00);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) push(8'(i));
    op("t3_pop_full", 1'b1, 8'h55, DATA_A, 1'b1, 1'b0, 8'h00, 8'h00);
    rd("t3_stat", STAT_A, 8'b10000_0_1_1);
    for (int i = 1; i < 16; i++) rd("t3_drain", DATA_A, 8'(i));
    rd("t3_last", DATA_A, 8'h55);
    rd("t3_stat_end", STAT_A, 8'h00);

    // Threshold interrupt
    wr(8'h31);
    check("t4_int_ctrl", {7'd0, int_req}, 8'h00);
    push(8'h10);
    check("t4_int_1", {7'd0, int_req}, 8'h00);
    push(8'h11);
    check("t4_int_2", {7'd0, int_req}, 8'h00);
    push(8'h12);
    check("t4_int_3", {7'd0, int_req}, 8'h01);
    rd("t4_pop", DATA_A, 8'h10);
    check("t4_int_pop", {7'd0, int_req}, 8'h00);
    push(8'h13);
    check("t4_int_again", {7'd0, int_req}, 8'h01);
    wr(8'h30);
    check("t4_int_dis", {7'd0, int_req}, 8'h00);
    rd("t4_ctrl", CTRL_A, 8'h30);

    // Flush with a byte arriving on the same cycle
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    op("t5_flush", 1'b1, 8'h99, CTRL_A, 1'b0, 1'b1, 8'h12, 8'h00);
    rd("t5_stat", STAT_A, 8'h00);
    rd("t5_ctrl", CTRL_A, 8'h10);
    push(8'h77);
    rd("t5_stat1", STAT_A, 8'b00001_0_0_1);
    rd("t5_rt", DATA_A, 8'h77);

    // Pointer wrap
    for (int i = 0; i < 9; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 9; i++) rd("t6_pre", DATA_A, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    rd("t6_stat", STAT_A, 8'b01010_0_0_1);
    for (int i = 0; i < 10; i++) rd("t6_wrap", DATA_A, 8'(8'h80 + i));

    // Asynchronous reset between edges
    wr(8'h11);
    push(8'h01);
    push(8'h02);
    check("t7_int_pre", {7'd0, int_req}, 8'h01);
    addr = STAT_A;
    #2 reset_n = 1'b0;
    #1 check("t7_stat", r_data, 8'h00);
    addr = CTRL_A;
    #1 check("t7_ctrl", r_data, 8'h10);
    check("t7_int", {7'd0, int_req}, 8'h00);
    addr = 8'h00;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    rd("t7_stat_after", STAT_A, 8'h00);

    repeat (3) @(posedge clock);
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
